// File: rtl/map_switch_ctrl_pkg.sv
// Shared definitions for the mapper switch sequencer: state encoding and
// default index settings matching the mapper hub's map_idx port.
package map_switch_ctrl_pkg;

    // Width of the hub's map_idx select and the index committed at reset.
    localparam int MAP_IDX_W   = 8;
    localparam int MAP_DEF_IDX = 0;

    // Switch sequence states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_BUS = 3'd1,
        ST_MUTE     = 3'd2,
        ST_RESET    = 3'd3,
        ST_RELEASE  = 3'd4
    } sw_state_e;

    // Counter width for a count that must reach value-1 without wrapping.
    function automatic int cnt_width(input int value);
        return $clog2(value) + 1;
    endfunction

endpackage

// File: rtl/map_switch_ctrl_idle_det.sv
// CPU bus idle detector: counts consecutive m2-low clk cycles and flags
// when the current cycle completes an IDLE_CYC-long quiet run.
module map_bus_idle_det
    import map_switch_ctrl_pkg::*;
#(
    parameter int IDLE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic m2,
    input  logic clr,
    input  logic hold,
    output logic idle_hit,
    output logic m2_low
);

    localparam int                CNT_W = cnt_width(IDLE_CYC);
    localparam logic [CNT_W-1:0] MATCH = CNT_W'(IDLE_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Run counter: restarts on m2 high, freezes on hold, saturates at MATCH.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (!hold) begin
            if (m2) begin
                cnt_d = '0;
            end else if (cnt_q != MATCH) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign m2_low   = ~m2;
    assign idle_hit = ~m2 && (cnt_q == MATCH);

endmodule

// File: rtl/map_switch_ctrl.sv
// Mapper switch sequencer: owns map_idx, mutes the hub on a quiet bus,
// commits the new index, holds the mapper in reset, and unmutes on m2 low.
// Handshake: a request transfers on any clk edge where req_valid and
// req_ready are both high; req_ready is only offered in IDLE without ss_act,
// and the requester keeps req_valid/req_idx stable until it transfers.
module map_switch_ctrl
    import map_switch_ctrl_pkg::*;
#(
    parameter int IDX_W    = MAP_IDX_W,
    parameter int DEF_IDX  = MAP_DEF_IDX,
    parameter int IDLE_CYC = 4,
    parameter int RST_CYC  = 16,
    parameter int TMO_CYC  = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m2,
    input  logic             ss_act,
    input  logic             req_valid,
    input  logic [IDX_W-1:0] req_idx,
    output logic             req_ready,
    output logic [IDX_W-1:0] map_idx,
    output logic             map_rst,
    output logic             out_mute,
    output logic             busy,
    output logic             done,
    output logic             forced
);

    localparam int TMO_W = cnt_width(TMO_CYC);
    localparam int RST_W = cnt_width(RST_CYC);

    sw_state_e        state_q, state_d;
    logic [IDX_W-1:0] map_idx_q, map_idx_d;
    logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
    logic             map_rst_q, map_rst_d;
    logic             out_mute_q, out_mute_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             forced_q, forced_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;

    logic accept;
    logic idle_hit;
    logic m2_low;
    logic det_hold;

    assign req_ready = (state_q == ST_IDLE) && !ss_act;
    assign accept    = req_valid && req_ready;
    // The idle run only accumulates while waiting for the bus and not frozen.
    assign det_hold  = (state_q != ST_WAIT_BUS) || ss_act;

    map_bus_idle_det #(
        .IDLE_CYC (IDLE_CYC)
    ) u_idle_det (
        .clk      (clk),
        .rst      (rst),
        .m2       (m2),
        .clr      (accept),
        .hold     (det_hold),
        .idle_hit (idle_hit),
        .m2_low   (m2_low)
    );

    // Next-state and next-output logic for the switch sequence.
    always_comb begin
        state_d    = state_q;
        map_idx_d  = map_idx_q;
        pend_idx_d = pend_idx_q;
        map_rst_d  = map_rst_q;
        out_mute_d = out_mute_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        forced_d   = forced_q;
        tmo_cnt_d  = tmo_cnt_q;
        rst_cnt_d  = rst_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    pend_idx_d = req_idx;
                    forced_d   = 1'b0;
                    tmo_cnt_d  = '0;
                    busy_d     = 1'b1;
                    state_d    = ST_WAIT_BUS;
                end
            end
            ST_WAIT_BUS: begin
                // Save-state activity freezes the wait entirely.
                if (!ss_act) begin
                    if (idle_hit) begin
                        out_mute_d = 1'b1;
                        state_d    = ST_MUTE;
                    end else if (tmo_cnt_q == TMO_W'(TMO_CYC - 1)) begin
                        out_mute_d = 1'b1;
                        forced_d   = 1'b1;
                        state_d    = ST_MUTE;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
            end
            ST_MUTE: begin
                // Outputs are already muted, so the index may change now.
                map_idx_d = pend_idx_q;
                map_rst_d = 1'b1;
                rst_cnt_d = '0;
                state_d   = ST_RESET;
            end
            ST_RESET: begin
                if (rst_cnt_q == RST_W'(RST_CYC - 1)) begin
                    map_rst_d = 1'b0;
                    state_d   = ST_RELEASE;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                // Unmute only outside an m2-high phase.
                if (m2_low) begin
                    out_mute_d = 1'b0;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset replays the mapper reset tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RESET;
            map_idx_q  <= IDX_W'(DEF_IDX);
            pend_idx_q <= IDX_W'(DEF_IDX);
            map_rst_q  <= 1'b1;
            out_mute_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            forced_q   <= 1'b0;
            tmo_cnt_q  <= '0;
            rst_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            map_idx_q  <= map_idx_d;
            pend_idx_q <= pend_idx_d;
            map_rst_q  <= map_rst_d;
            out_mute_q <= out_mute_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            forced_q   <= forced_d;
            tmo_cnt_q  <= tmo_cnt_d;
            rst_cnt_q  <= rst_cnt_d;
        end
    end

    assign map_idx  = map_idx_q;
    assign map_rst  = map_rst_q;
    assign out_mute = out_mute_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign forced   = forced_q;

endmodule

// File: doc/map_switch_ctrl.md
Name: map_switch_ctrl

Overview:
- Sequencer that owns the active mapper index feeding the mapper hub's output select.
- Accepts a switch request from the menu/firmware side, waits for a quiet CPU bus, and mutes hub outputs.
- Commits the new index, holds the selected mapper in reset for a fixed time, then unmutes on a safe bus boundary.
- Guarantees map_idx never changes while any mapper drives the cartridge bus.

Parameters:
- IDX_W, 8: mapper index width.
- DEF_IDX, 0: index committed at reset.
- IDLE_CYC, 4: consecutive m2-low clk cycles that count as bus idle.
- RST_CYC, 16: clk cycles map_rst is held after commit.
- TMO_CYC, 4096: maximum WAIT_BUS cycles before a forced switch.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- m2  in  1  CPU phi2, already synchronised to clk.
- ss_act  in  1  save-state engine active; blocks new switches.
- req_valid  in  1  switch request.
- req_idx  in  IDX_W  requested mapper index.
- req_ready  out  1  request accepted this cycle when req_valid=1.
- map_idx  out  IDX_W  active mapper index to the hub.
- map_rst  out  1  reset to mapper cores.
- out_mute  out  1  hub forces map_out to the inactive/nominal value.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at completion.
- forced  out  1  sticky; set when a timeout forced the switch; cleared by the next accepted request or by rst.

Behaviour:
- All outputs registered. States: IDLE, WAIT_BUS, MUTE, RESET, RELEASE.
- rst (synchronous):
  - map_idx=DEF_IDX, map_rst=1, out_mute=1, busy=1, done=0, forced=0, req_ready=0.
  - State=RESET, rst_cnt=0.
  - Power-up therefore runs the RESET→RELEASE tail.
- req_ready = (state==IDLE) & ~ss_act, combinational from registered state.
- IDLE:
  - Handshake req_valid & req_ready latches pend_idx=req_idx, clears forced, clears idle_cnt/tmo_cnt, goes to WAIT_BUS.
  - Requesting the current index still runs the full sequence; this is the mapper re-init path.
- WAIT_BUS:
  - idle_cnt increments while m2=0 and clears on m2=1.
  - idle_cnt==IDLE_CYC-1 with m2=0 → MUTE.
  - tmo_cnt increments each cycle. tmo_cnt==TMO_CYC-1 → MUTE and set forced.
  - Idle match takes priority over timeout on the same cycle; forced stays 0.
  - While ss_act=1, both counters hold and no transition occurs.
- MUTE:
  - out_mute=1 registered on entry, one cycle.
  - Next cycle: map_idx=pend_idx, map_rst=1, rst_cnt=0, go to RESET.
  - map_idx changes only with out_mute already high.
- RESET:
  - map_rst=1 and out_mute=1.
  - rst_cnt counts 0..RST_CYC-1, then map_rst=0 and go to RELEASE.
  - Total map_rst high time is exactly RST_CYC cycles.
- RELEASE:
  - out_mute stays 1 until the first cycle with m2=0.
  - On that cycle: out_mute=0, done=1 for one cycle, go to IDLE.
  - Unmute never occurs inside an m2-high phase.
- ss_act in MUTE/RESET/RELEASE is ignored; the sequence finishes.
- rst mid-sequence aborts and applies the reset values. pend_idx is discarded and map_idx returns to DEF_IDX.
- Counter widths are $clog2(param)+1. Comparisons use equality, so there is no wrap.
- req_valid outside IDLE is ignored, not queued. The requester holds it until req_ready.

Decomposition:
- Shared package/defs: state encoding constants, IDX_W default matching the hub's map_idx width, DEF_IDX.
- One sub-module is natural: map_bus_idle_det (m2-low run counter with IDLE_CYC match and a hold input). Used in WAIT_BUS, with its m2-low view reused in RELEASE.
- FSM and counters stay in map_switch_ctrl.

Test Plan:
- Reset release, m2 held low:
  - map_rst high for 1 cycle (rst) plus RST_CYC=16 cycles; out_mute high throughout.
  - done pulses once; map_idx=0; busy falls with done.
- req_idx=30 in IDLE, m2 toggling 1-high/1-low:
  - Stays in WAIT_BUS.
  - After m2 is held low 4 cycles: MUTE, then map_idx=30 with out_mute already 1; 16-cycle map_rst; done; forced=0.
- m2 held high, request idx 233:
  - Exactly 4096 WAIT_BUS cycles, then switch with forced=1.
  - Next accepted request clears forced.
- ss_act=1 during WAIT_BUS for 100 cycles with m2 low:
  - Counters freeze, no switch.
  - Switch completes 4 low cycles after ss_act falls.
  - Also: req_ready=0 while ss_act=1 in IDLE.
- rst asserted mid-RESET after switching to 162:
  - map_idx=0 next cycle and power-up sequence reruns.
  - req_valid during busy is ignored, with no second switch.
- RELEASE entered with m2=1 for 5 cycles:
  - out_mute stays 1 until the first m2=0 cycle; done coincides with unmute.
